// File: rtl/jstk2_spi_responder_if.sv
// SPI link between a PmodJSTK2-style master and the joystick responder.
//   SS      : slave select, active low (master -> slave)
//   SCLK    : serial clock, idle low, mode 0 (master -> slave)
//   MOSI    : master-out data (master -> slave)
//   MISO    : slave-out data (slave -> master)
//   miso_oe : high while the slave drives MISO (slave -> master/pad)
interface jstk2_spi_responder_if;
  logic SS;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic miso_oe;

  modport master (output SS, SCLK, MOSI, input MISO, miso_oe);
  modport slave  (input SS, SCLK, MOSI, output MISO, miso_oe);
endinterface

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave emulating a PmodJSTK2 joystick. Each 40-bit frame returns
// {xpos[7:0], xpos[9:8], ypos[7:0], ypos[9:8], buttons} and accepts a command
// byte plus R,G,B; a CMD_SET_RGB command updates the rgb output.
// Ports:
//   CLK, RST          : system clock, asynchronous active-high reset
//   xpos, ypos        : 10-bit joystick position, sampled at frame start
//   buttons           : bit0 stick button, bit1 trigger
//   spi               : SPI link (slave modport)
//   rgb, rgb_valid    : last accepted {R,G,B} and its one-cycle update pulse
//   frame_done        : one-cycle pulse after a complete 40-bit frame
//   frame_err         : one-cycle pulse after a frame of any other length
//   busy              : high while a frame is being shifted
//
// state | meaning
// IDLE  | waiting for SS falling edge, MISO held at 0
// SHIFT | SS low, shifting bits on SCLK edges
// DONE  | one cycle after SS rises, frame length/command evaluated
module jstk2_spi_responder #(
  parameter int          SYNC_STAGES = 2,   // must be 2 or more
  parameter logic [7:0]  CMD_SET_RGB = 8'h84
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [9:0]             xpos,
  input  logic [9:0]             ypos,
  input  logic [1:0]             buttons,
  jstk2_spi_responder_if.slave   spi,
  output logic [23:0]            rgb,
  output logic                   rgb_valid,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_s, sclk_s, mosi_s;
  logic ss_d, sclk_d;
  logic ss_armed;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [39:0] tx_sr;
  logic [39:0] tx_snap;
  logic [31:0] rx_sr;
  logic [5:0]  bit_cnt;

  logic done_ok, done_err, rgb_load;

  // SS chain resets low so that a frame already in progress when reset
  // releases never produces a falling edge; only a real high-to-low
  // transition on the pin starts a frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b0;
      sclk_d    <= 1'b0;
      ss_armed  <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
      if (ss_s)
        ss_armed <= 1'b1;
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // Output enable stays off after reset until SS has been seen high, which
  // keeps the reset value at 0 even with the SS chain reset low.
  assign spi.miso_oe = ss_armed & ~ss_s;
  assign spi.MISO    = (state == SHIFT) & tx_sr[39];
  assign busy        = (state == SHIFT);

  assign tx_snap = {xpos[7:0], 6'b0, xpos[9:8], ypos[7:0], 6'b0, ypos[9:8],
                    6'b0, buttons};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    rgb_load  = 1'b0;
    case (state)
      IDLE:  if (ss_fall) state_nxt = SHIFT;
      SHIFT: if (ss_rise) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        if (bit_cnt == 6'd40) begin
          done_ok  = 1'b1;
          rgb_load = (rx_sr[31:24] == CMD_SET_RGB);
        end else begin
          done_err = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SCLK edges and the SS rise share a cycle safely: the shift/count updates
  // land together with the move to DONE, so DONE sees the final count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      rgb        <= '0;
      rgb_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rgb_valid  <= rgb_load;
      frame_done <= done_ok;
      frame_err  <= done_err;
      if (rgb_load)
        rgb <= rx_sr[23:0];
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_sr   <= tx_snap;
            rx_sr   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            // Only command and R,G,B are kept; byte 4 is never needed.
            if (bit_cnt < 6'd32)
              rx_sr <= {rx_sr[30:0], mosi_s};
            if (bit_cnt != 6'd41)
              bit_cnt <= bit_cnt + 6'd1;
          end
          // Zeros fill in behind, so bits past 40 read back as 0.
          if (sclk_fall)
            tx_sr <= {tx_sr[38:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jstk2_spi_responder.md
Name: jstk2_spi_responder

Overview:
- SPI mode-0 slave that emulates the PmodJSTK2 joystick module on the far end of the JSTK SPI link.
- Answers each 5-byte master transaction with a snapshot of local joystick position and button state.
- Decodes the master's command frame and, on a set-RGB command, presents the 24-bit RGB value to downstream logic.
- Used as a stand-in peripheral for bench and board bring-up of the joystick master path, and as the slave side of a second ICEStick.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on SS, SCLK and MOSI (minimum 2).
- CMD_SET_RGB, 8'h84, command byte that updates the rgb output.

Ports:
- CLK  in  1  system clock (12 MHz).
- RST  in  1  asynchronous, active-high reset.
- xpos  in  10  joystick X position, 0..1023.
- ypos  in  10  joystick Y position, 0..1023.
- buttons  in  2  bit0 = stick button, bit1 = trigger.
- SS  in  1  slave select from master, active low.
- SCLK  in  1  serial clock from master, idle low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- miso_oe  out  1  high while the slave drives MISO, i.e. while SS is low.
- rgb  out  24  last accepted RGB value, {R,G,B}.
- rgb_valid  out  1  one-CLK pulse when rgb updates.
- frame_done  out  1  one-CLK pulse at the end of every complete 40-bit frame.
- frame_err  out  1  one-CLK pulse when a frame ends with a bit count other than 40.
- busy  out  1  high while in state SHIFT.

Behaviour:
- Reset values:
  - MISO=0, miso_oe=0, rgb=24'h000000.
  - rgb_valid=0, frame_done=0, frame_err=0, busy=0.
  - State IDLE, bit counter 0, both shift registers 0.
- Input conditioning:
  - SS, SCLK and MOSI pass through SYNC_STAGES flip-flops.
  - Edges are detected with one further register stage.
  - Internal latency from a pin edge to its action is SYNC_STAGES+1 CLK cycles.
  - Supported SCLK half-period: at least SYNC_STAGES+2 CLK cycles.
- Frame format, 40 bits, MSB first per byte, byte 0 first:
  - TX byte0 = xpos[7:0].
  - TX byte1 = {6'b0, xpos[9:8]}.
  - TX byte2 = ypos[7:0].
  - TX byte3 = {6'b0, ypos[9:8]}.
  - TX byte4 = {6'b0, buttons}.
  - RX byte0 = command, bytes1-3 = R,G,B, byte4 ignored.
- State machine:
  - IDLE:
    - On synchronized SS falling edge: snapshot xpos, ypos and buttons into the TX shift register.
    - Clear the bit counter, drive MISO = TX bit 39, go to SHIFT.
    - Input changes after the snapshot do not affect the current frame.
  - SHIFT:
    - On synchronized SCLK rising edge: shift the synchronized MOSI into the RX register LSB and increment the bit counter, saturating at 41.
    - On synchronized SCLK falling edge: shift TX left and drive MISO = next bit.
    - Once 40 bits are consumed, MISO=0 for any further bits.
    - On synchronized SS rising edge: go to DONE.
  - DONE, one cycle, then IDLE:
    - Counter == 40: pulse frame_done.
    - Counter == 40 and RX byte0 == CMD_SET_RGB: load rgb from RX bytes 1-3 and pulse rgb_valid in the same cycle.
    - Any other command: rgb is unchanged, no error.
    - Counter != 40, whether short or overrun: pulse frame_err only; rgb is unchanged, no frame_done.
- Output timing:
  - miso_oe follows the synchronized SS inverted.
  - busy = (state == SHIFT).
  - MISO is forced to 0 in IDLE.
- Boundary conditions:
  - SCLK edges while SS is high are ignored.
  - SS low for zero SCLK edges is a frame_err.
  - Asserting RST mid-frame returns everything to reset values immediately.
  - After RST releases, a frame already in progress (SS already low) is not joined; the block waits for the next SS falling edge.
  - SS rising and SCLK edge detected in the same CLK cycle: the SCLK edge is processed first, then frame end is evaluated.

Test Plan:
- xpos=10'h2A5, ypos=10'h13C, buttons=2'b10; master sends 40'h84_FF8000_00 at SCLK = CLK/16 -> MISO stream A5 02 3C 01 02; rgb=24'hFF8000; rgb_valid and frame_done pulse once each.
- Master sends 40'hC0_123456_00 -> frame_done pulses, rgb_valid does not, rgb holds its previous value, MISO data still correct.
- SS released after 23 bits -> frame_err pulses, no frame_done, rgb unchanged; the next full 0x84 frame updates rgb normally.
- 48-bit frame -> bytes 6 on MISO read 00, frame_err pulses, rgb unchanged.
- xpos changed from 10'h3FF to 10'h000 mid-frame -> MISO still returns FF 03 for X bytes; the next frame returns 00 00.
- RST asserted at bit 17 of a 0x84 frame -> all outputs 0 asynchronously, rgb=0; the in-progress frame is not completed; the next clean frame works.
